// File: rtl/nxor_chk_pkg.sv
// nxor_chk_pkg: shared types and helpers for the XNOR response checker.
//   chk_state_e : checker FSM state encoding
//   CMP_STAGES  : latency of the compare stage (cycles)
//   MAX_W       : widest counter the saturating helper handles
//   sat_inc()   : increment that sticks at a caller-supplied ceiling
package nxor_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

  localparam int CMP_STAGES = 1;
  localparam int MAX_W      = 64;

  function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v,
                                               input logic [MAX_W-1:0] maxv);
    return (v == maxv) ? v : v + {{(MAX_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/nxor_chk_cmp.sv
// nxor_chk_cmp: registered compare stage of the XNOR response checker.
// Captures ~(a^b), c and the vector index on each accepted vector; one
// cycle later raises mis for a single cycle if any bit of c differs.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   in_vld            accepted vector this cycle
//   in_a, in_b, in_c  operands and observed result
//   in_idx            0-based index of the vector
//   mis               mismatch strobe (registered vector)
//   out_idx           index of the registered vector
//   cap_a/b/c         registered operands/result (NXOR_CHK_CAPTURE_EN only)
module nxor_chk_cmp
  import nxor_chk_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [CNT_W-1:0] in_idx,
  output logic             mis,
  output logic [CNT_W-1:0] out_idx
`ifdef NXOR_CHK_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] cap_a,
  output logic [WIDTH-1:0] cap_b,
  output logic [WIDTH-1:0] cap_c
`endif
);

  logic [CMP_STAGES:0] vld_pipe;
  logic [WIDTH-1:0]    exp_q;
  logic [WIDTH-1:0]    c_q;
  logic [CNT_W-1:0]    idx_q;

  assign vld_pipe[0] = in_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[CMP_STAGES:1] <= '0;
      exp_q                  <= '0;
      c_q                    <= '0;
      idx_q                  <= '0;
    end else begin
      vld_pipe[CMP_STAGES:1] <= vld_pipe[CMP_STAGES-1:0];
      // only load on a real transfer so idle cycles keep the last vector
      if (in_vld) begin
        exp_q <= ~(in_a ^ in_b);
        c_q   <= in_c;
        idx_q <= in_idx;
      end
    end
  end

  assign mis     = vld_pipe[CMP_STAGES] && (exp_q != c_q);
  assign out_idx = idx_q;

`ifdef NXOR_CHK_CAPTURE_EN
  logic [WIDTH-1:0] a_q, b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (in_vld) begin
      a_q <= in_a;
      b_q <= in_b;
    end
  end

  assign cap_a = a_q;
  assign cap_b = b_q;
  assign cap_c = c_q;
`endif

endmodule

// File: rtl/nxor_resp_checker.sv
// nxor_resp_checker: checks an XNOR gate's responses c == ~(a^b).
// A start pulse (IDLE/DONE) latches exp_cnt and opens a run; vectors are
// accepted over in_valid/in_ready, compared one cycle later, and counted.
// Optional macro NXOR_CHK_CAPTURE_EN adds fail_a/fail_b/fail_c capture of
// the first mismatching vector.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   start, exp_cnt           run start pulse and vector count
//   in_valid, in_ready       input handshake
//   in_a, in_b, in_c         operands and DUT result
//   busy, done, pass         run status
//   vec_cnt, err_cnt         accepted vectors, saturating mismatches
//   fail_idx                 index of first mismatching vector
//   fail_a, fail_b, fail_c   first mismatching vector (macro only)
module nxor_resp_checker
  import nxor_chk_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] exp_cnt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] fail_idx
`ifdef NXOR_CHK_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_c
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_e       state, state_nxt;
  logic [CNT_W-1:0] exp_lat;
  logic [CNT_W-1:0] vec_inc;
  logic             start_ok;
  logic             xfer;
  logic             mis;
  logic [CNT_W-1:0] cmp_idx;

  assign start_ok = start && (state == IDLE || state == DONE);
  assign xfer     = in_valid && in_ready;
  assign vec_inc  = vec_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  assign pass     = done && (err_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (exp_cnt == '0) ? DONE : RUN;
      RUN:        if (xfer && vec_inc == exp_lat) state_nxt = DRAIN;
      DRAIN:      state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // mis can only fire in RUN/DRAIN, so it never collides with start_ok
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_lat  <= '0;
      vec_cnt  <= '0;
      err_cnt  <= '0;
      fail_idx <= '0;
    end else if (start_ok) begin
      exp_lat  <= exp_cnt;
      vec_cnt  <= '0;
      err_cnt  <= '0;
      fail_idx <= '0;
    end else begin
      if (xfer) vec_cnt <= vec_inc;
      if (mis) begin
        err_cnt <= CNT_W'(sat_inc(MAX_W'(err_cnt), MAX_W'(CNT_MAX)));
        if (err_cnt == '0) fail_idx <= cmp_idx;
      end
    end
  end

`ifdef NXOR_CHK_CAPTURE_EN
  logic [WIDTH-1:0] cap_a, cap_b, cap_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_a <= '0;
      fail_b <= '0;
      fail_c <= '0;
    end else if (start_ok) begin
      fail_a <= '0;
      fail_b <= '0;
      fail_c <= '0;
    end else if (mis && err_cnt == '0) begin
      fail_a <= cap_a;
      fail_b <= cap_b;
      fail_c <= cap_c;
    end
  end
`endif

  nxor_chk_cmp #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cmp (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (xfer),
    .in_a    (in_a),
    .in_b    (in_b),
    .in_c    (in_c),
    .in_idx  (vec_cnt),
    .mis     (mis),
    .out_idx (cmp_idx)
`ifdef NXOR_CHK_CAPTURE_EN
    ,
    .cap_a   (cap_a),
    .cap_b   (cap_b),
    .cap_c   (cap_c)
`endif
  );

endmodule

// File: tb/tb_nxor_resp_checker.sv
module tb_nxor_resp_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] exp_cnt;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b, in_c;
  logic        busy, done, pass;
  logic [15:0] vec_cnt, err_cnt, fail_idx;
`ifdef NXOR_CHK_CAPTURE_EN
  logic [31:0] fail_a, fail_b, fail_c;
`endif

  // small instance for the saturation case
  logic       s_start;
  logic [1:0] s_exp;
  logic       s_valid, s_ready;
  logic [7:0] s_a, s_b, s_c;
  logic       s_busy, s_done, s_pass;
  logic [1:0] s_vec, s_err, s_fidx;
`ifdef NXOR_CHK_CAPTURE_EN
  logic [7:0] s_fa, s_fb, s_fc;
`endif

  always #5 clk = ~clk;

  nxor_resp_checker #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_cnt(exp_cnt),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt), .fail_idx(fail_idx)
`ifdef NXOR_CHK_CAPTURE_EN
    , .fail_a(fail_a), .fail_b(fail_b), .fail_c(fail_c)
`endif
  );

  nxor_resp_checker #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .exp_cnt(s_exp),
    .in_valid(s_valid), .in_ready(s_ready),
    .in_a(s_a), .in_b(s_b), .in_c(s_c),
    .busy(s_busy), .done(s_done), .pass(s_pass),
    .vec_cnt(s_vec), .err_cnt(s_err), .fail_idx(s_fidx)
`ifdef NXOR_CHK_CAPTURE_EN
    , .fail_a(s_fa), .fail_b(s_fb), .fail_c(s_fc)
`endif
  );

  int npass = 0, ntot = 0, nfail = 0;
  logic [31:0] qa[$], qb[$], qc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    qa.push_back(a); qb.push_back(b); qc.push_back(c);
  endtask

  // random vectors; errpct percent of them get 1..3 flipped result bits
  task automatic fill_rand(input int n, input int errpct);
    logic [31:0] a, b, c;
    qa.delete(); qb.delete(); qc.delete();
    for (int i = 0; i < n; i++) begin
      a = $urandom; b = $urandom; c = ~(a ^ b);
      if ($urandom_range(0, 99) < errpct)
        for (int k = 0; k <= $urandom_range(0, 2); k++) c[$urandom_range(0, 31)] ^= 1'b1;
      push(a, b, c);
    end
  endtask

  // vmode: 0 always valid, 1 toggling, 2 random
  task automatic do_run(input int n, input int vmode, input string tag);
    int acc, nerr, first, cyc;
    logic v;
    acc = 0; nerr = 0; first = -1; cyc = 0;
    exp_cnt = n[15:0]; start = 1'b1;
    step();
    start = 1'b0; exp_cnt = '0;
    if (n == 0) begin
      chk({tag, "_done"}, done, 1);
      chk({tag, "_pass"}, pass, 1);
      chk({tag, "_vec"}, vec_cnt, 0);
      chk({tag, "_rdy"}, in_ready, 0);
      return;
    end
    while (acc < n && cyc < 400) begin
      chk({tag, "_rdy_run"}, in_ready, 1);
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      in_valid = v; in_a = qa[acc]; in_b = qb[acc]; in_c = qc[acc];
      step();
      cyc++;
      if (v) begin
        if (qc[acc] != ~(qa[acc] ^ qb[acc])) begin
          nerr++;
          if (first < 0) first = acc;
        end
        acc++;
      end
      chk({tag, "_veccnt"}, vec_cnt, acc);
    end
    if (acc < n) chk({tag, "_timeout"}, acc, n);
    // producer keeps offering vectors: none may be accepted from here on
    in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_c = $urandom;
    chk({tag, "_rdy_drain"}, in_ready, 0);
    chk({tag, "_busy_drain"}, busy, 1);
    chk({tag, "_done_early"}, done, 0);
    step();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_vec"}, vec_cnt, n);
    chk({tag, "_err"}, err_cnt, nerr);
    chk({tag, "_fidx"}, fail_idx, (first < 0) ? 0 : first);
    chk({tag, "_pass"}, pass, nerr == 0);
`ifdef NXOR_CHK_CAPTURE_EN
    chk({tag, "_fail_c"}, fail_c, (first < 0) ? 32'd0 : qc[first]);
    chk({tag, "_fail_a"}, fail_a, (first < 0) ? 32'd0 : qa[first]);
`endif
    step(); step();
    in_valid = 1'b0;
    chk({tag, "_vec_hold"}, vec_cnt, n);
    chk({tag, "_err_hold"}, err_cnt, nerr);
  endtask

  initial begin
    rst_n = 1'b0; start = 0; exp_cnt = 0; in_valid = 0; in_a = 0; in_b = 0; in_c = 0;
    s_start = 0; s_exp = 0; s_valid = 0; s_a = 0; s_b = 0; s_c = 0;
    step(); step();
    chk("rst_rdy", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_vec", vec_cnt, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_fidx", fail_idx, 0);
    rst_n = 1'b1;
    step();
    chk("idle_rdy", in_ready, 0);

    // all-good directed vectors
    qa.delete(); qb.delete(); qc.delete();
    push(32'h0, 32'h0, 32'hFFFFFFFF);
    push(32'hFFFFFFFF, 32'h0, 32'h0);
    push(32'h0, 32'hFFFFFFFF, 32'h0);
    push(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_run(4, 0, "good4");

    // second vector off by one bit
    qa.delete(); qb.delete(); qc.delete();
    push(32'h0, 32'h007FA509, 32'hFF805AF6);
    push(32'h0, 32'h007FA509, 32'hFF805AF7);
    do_run(2, 0, "bad1");

    fill_rand(3, 0);
    do_run(3, 1, "toggle3");

    do_run(0, 0, "zero");

    for (int r = 0; r < 4; r++) begin
      fill_rand(20 + r * 7, 30);
      do_run(20 + r * 7, 2, $sformatf("rand%0d", r));
    end

    // reset in the middle of a run
    qa.delete(); qb.delete(); qc.delete();
    push(32'h1, 32'h2, 32'h0);
    push(32'h3, 32'h4, 32'h0);
    exp_cnt = 16'd5; start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_a = qa[0]; in_b = qb[0]; in_c = qc[0];
    step();
    in_a = qa[1]; in_b = qb[1]; in_c = qc[1];
    step();
    in_valid = 1'b0;
    step();
    chk("mid_vec", vec_cnt, 2);
    chk("mid_err", err_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rdy", in_ready, 0);
    chk("arst_vec", vec_cnt, 0);
    chk("arst_err", err_cnt, 0);
    chk("arst_fidx", fail_idx, 0);
    chk("arst_done", done, 0);
    step();
    rst_n = 1'b1;
    step();
    fill_rand(6, 20);
    do_run(6, 0, "restart");

    // saturation on a 2-bit counter instance
    s_exp = 2'd3; s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_a = 8'($urandom); s_b = 8'($urandom);
      s_c = ~(s_a ^ s_b) ^ 8'h81;
      step();
    end
    s_valid = 1'b0;
    chk("sat_rdy", s_ready, 0);
    step();
    chk("sat_done", s_done, 1);
    chk("sat_vec", s_vec, 3);
    chk("sat_err", s_err, 3);
    chk("sat_pass", s_pass, 0);
    chk("sat_fidx", s_fidx, 0);
    s_valid = 1'b1;
    step(); step(); step();
    s_valid = 1'b0;
    chk("sat_err_hold", s_err, 3);
    chk("sat_vec_hold", s_vec, 3);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
